// File: rtl/memory_controller.sv
// memory_controller: arbitrates committed stores, loads and instruction fetches
// onto the byte-serial RAM/IO bus and reassembles load/fetch results.
module memory_controller #(
    parameter int XLEN = 32,
    parameter int ROB_SIZE_WIDTH = 3,
    parameter int INST_OP_WIDTH = 6,
    parameter logic [INST_OP_WIDTH-1:0] OP_LB  = 6'd10,
    parameter logic [INST_OP_WIDTH-1:0] OP_LH  = 6'd11,
    parameter logic [INST_OP_WIDTH-1:0] OP_LW  = 6'd12,
    parameter logic [INST_OP_WIDTH-1:0] OP_LBU = 6'd13,
    parameter logic [INST_OP_WIDTH-1:0] OP_LHU = 6'd14,
    parameter logic [INST_OP_WIDTH-1:0] OP_SB  = 6'd15,
    parameter logic [INST_OP_WIDTH-1:0] OP_SH  = 6'd16,
    parameter logic [INST_OP_WIDTH-1:0] OP_SW  = 6'd17
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rdy,
    input  logic                      flush,
    input  logic                      io_buffer_full,
    input  logic                      rob_mem_enable,
    input  logic [INST_OP_WIDTH-1:0]  rob_mem_op,
    input  logic [XLEN-1:0]           rob_mem_addr,
    input  logic [XLEN-1:0]           rob_mem_val,
    input  logic                      lsb_load_enable,
    input  logic [INST_OP_WIDTH-1:0]  lsb_load_op,
    input  logic [XLEN-1:0]           lsb_load_addr,
    input  logic [ROB_SIZE_WIDTH-1:0] lsb_load_id,
    input  logic                      if_enable,
    input  logic [XLEN-1:0]           if_addr,
    input  logic [7:0]                mem_din,
    output logic [7:0]                mem_dout,
    output logic [XLEN-1:0]           mem_a,
    output logic                      mem_wr,
    output logic                      mem_busy,
    output logic                      mem_data_ready,
    output logic [XLEN-1:0]           mem_data,
    output logic [ROB_SIZE_WIDTH-1:0] mem_id,
    output logic                      if_ready,
    output logic [XLEN-1:0]           if_data
);
    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [XLEN-1:0] IO_BASE = XLEN'(32'h30000);
    localparam logic [XLEN-1:0] IO_MASK = ~XLEN'(7);

    function automatic logic [2:0] op_len(input logic [INST_OP_WIDTH-1:0] op);
        return (op == OP_LB || op == OP_LBU || op == OP_SB) ? 3'd1 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 3'd2 : 3'd4;
    endfunction

    function automatic logic io_hit(input logic [XLEN-1:0] a);
        return (a & IO_MASK) == IO_BASE;
    endfunction

    state_t                    state_q, state_d;
    logic [2:0]                cnt_q, cnt_d;
    logic [2:0]                len_q, len_d;
    logic [XLEN-1:0]           addr_q, addr_d;
    logic [XLEN-1:0]           val_q, val_d;
    logic [INST_OP_WIDTH-1:0]  op_q, op_d;
    logic [ROB_SIZE_WIDTH-1:0] id_q, id_d;
    logic                      fetch_q, fetch_d;
    logic [XLEN-1:0]           data_q, data_d;
    logic [XLEN-1:0]           mem_a_q, mem_a_d;
    logic [7:0]                mem_dout_q, mem_dout_d;
    logic                      mem_wr_q, mem_wr_d;
    logic                      mem_data_ready_q, mem_data_ready_d;
    logic [XLEN-1:0]           mem_data_q, mem_data_d;
    logic [ROB_SIZE_WIDTH-1:0] mem_id_q, mem_id_d;
    logic                      if_ready_q, if_ready_d;
    logic [XLEN-1:0]           if_data_q, if_data_d;

    logic            idle, take_store, take_load, take_fetch, rd_ok;
    logic            acc_stall, wr_stall;
    logic [2:0]      rd_nxt;
    logic [1:0]      byte_idx;
    logic [XLEN-1:0] wr_addr, rd_word, ld_ext;

    // loads/fetches wait out a cycle in which a result is being returned
    assign idle       = state_q == IDLE;
    assign take_store = idle && rob_mem_enable;
    assign rd_ok      = idle && !rob_mem_enable && !flush && !mem_data_ready_q && !if_ready_q;
    assign take_load  = rd_ok && lsb_load_enable;
    assign take_fetch = rd_ok && !lsb_load_enable && if_enable;

    assign rd_nxt    = cnt_q + 3'd1;
    assign byte_idx  = cnt_q[1:0] - 2'd1;
    assign wr_addr   = addr_q + XLEN'(cnt_q);
    assign acc_stall = io_buffer_full && io_hit(rob_mem_addr);
    assign wr_stall  = io_buffer_full && io_hit(wr_addr);

    always_comb begin
        rd_word = data_q;
        rd_word[{byte_idx, 3'b000} +: 8] = mem_din;
    end

    always_comb begin
        ld_ext = (op_q == OP_LB)  ? {{(XLEN-8){rd_word[7]}}, rd_word[7:0]} :
                 (op_q == OP_LH)  ? {{(XLEN-16){rd_word[15]}}, rd_word[15:0]} :
                 (op_q == OP_LBU) ? {{(XLEN-8){1'b0}}, rd_word[7:0]} :
                 (op_q == OP_LHU) ? {{(XLEN-16){1'b0}}, rd_word[15:0]} : rd_word;
    end

    always_ff @(posedge clk) begin
        if (rdy) begin
            if (rst) begin
                state_q          <= IDLE;
                cnt_q            <= '0;
                len_q            <= '0;
                addr_q           <= '0;
                val_q            <= '0;
                op_q             <= '0;
                id_q             <= '0;
                fetch_q          <= 1'b0;
                data_q           <= '0;
                mem_a_q          <= '0;
                mem_dout_q       <= '0;
                mem_wr_q         <= 1'b0;
                mem_data_ready_q <= 1'b0;
                mem_data_q       <= '0;
                mem_id_q         <= '0;
                if_ready_q       <= 1'b0;
                if_data_q        <= '0;
            end else begin
                state_q          <= state_d;
                cnt_q            <= cnt_d;
                len_q            <= len_d;
                addr_q           <= addr_d;
                val_q            <= val_d;
                op_q             <= op_d;
                id_q             <= id_d;
                fetch_q          <= fetch_d;
                data_q           <= data_d;
                mem_a_q          <= mem_a_d;
                mem_dout_q       <= mem_dout_d;
                mem_wr_q         <= mem_wr_d;
                mem_data_ready_q <= mem_data_ready_d;
                mem_data_q       <= mem_data_d;
                mem_id_q         <= mem_id_d;
                if_ready_q       <= if_ready_d;
                if_data_q        <= if_data_d;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = take_store ? WRITE : (take_load || take_fetch) ? READ : IDLE;
            READ:    state_d = (flush || cnt_q == len_q) ? IDLE : READ;
            WRITE:   state_d = (cnt_q == len_q) ? IDLE : WRITE;
            default: state_d = IDLE;
        endcase
    end

    // cnt_q counts READ edges since accept, or bytes already written in WRITE
    always_comb begin
        cnt_d            = cnt_q;
        len_d            = len_q;
        addr_d           = addr_q;
        val_d            = val_q;
        op_d             = op_q;
        id_d             = id_q;
        fetch_d          = fetch_q;
        data_d           = data_q;
        mem_a_d          = mem_a_q;
        mem_dout_d       = mem_dout_q;
        mem_wr_d         = mem_wr_q;
        mem_data_ready_d = 1'b0;
        mem_data_d       = mem_data_q;
        mem_id_d         = mem_id_q;
        if_ready_d       = 1'b0;
        if_data_d        = if_data_q;
        if (take_store) begin
            addr_d     = rob_mem_addr;
            val_d      = rob_mem_val;
            op_d       = rob_mem_op;
            len_d      = op_len(rob_mem_op);
            mem_a_d    = acc_stall ? '0 : rob_mem_addr;
            mem_wr_d   = !acc_stall;
            mem_dout_d = rob_mem_val[7:0];
            cnt_d      = acc_stall ? 3'd0 : 3'd1;
        end else if (take_load || take_fetch) begin
            addr_d   = take_load ? lsb_load_addr : if_addr;
            op_d     = lsb_load_op;
            len_d    = take_load ? op_len(lsb_load_op) : 3'd4;
            id_d     = lsb_load_id;
            fetch_d  = take_fetch;
            data_d   = '0;
            mem_a_d  = take_load ? lsb_load_addr : if_addr;
            mem_wr_d = 1'b0;
            cnt_d    = '0;
        end else if (state_q == READ) begin
            if (flush) begin
                mem_a_d = '0;
                cnt_d   = '0;
            end else begin
                mem_a_d = (rd_nxt < len_q) ? addr_q + XLEN'(rd_nxt) : '0;
                data_d  = (cnt_q != 3'd0) ? rd_word : data_q;
                cnt_d   = (cnt_q == len_q) ? 3'd0 : rd_nxt;
                if (cnt_q == len_q) begin
                    mem_data_ready_d = !fetch_q;
                    if_ready_d       = fetch_q;
                    mem_data_d       = fetch_q ? mem_data_q : ld_ext;
                    mem_id_d         = fetch_q ? mem_id_q : id_q;
                    if_data_d        = fetch_q ? rd_word : if_data_q;
                end
            end
        end else if (state_q == WRITE) begin
            // parking the bus at 0 avoids a side-effecting read of an IO address
            if (cnt_q == len_q) begin
                mem_wr_d = 1'b0;
                mem_a_d  = '0;
                cnt_d    = '0;
            end else begin
                mem_a_d    = wr_stall ? '0 : wr_addr;
                mem_wr_d   = !wr_stall;
                mem_dout_d = wr_stall ? mem_dout_q : val_q[{cnt_q[1:0], 3'b000} +: 8];
                cnt_d      = wr_stall ? cnt_q : cnt_q + 3'd1;
            end
        end
    end

    assign mem_busy       = !idle;
    assign mem_a          = mem_a_q;
    assign mem_dout       = mem_dout_q;
    assign mem_wr         = mem_wr_q;
    assign mem_data_ready = mem_data_ready_q;
    assign mem_data       = mem_data_q;
    assign mem_id         = mem_id_q;
    assign if_ready       = if_ready_q;
    assign if_data        = if_data_q;

    store_while_busy: assert property (@(posedge clk) !(rdy && !rst && rob_mem_enable && !idle));
endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sole owner of the CPU's byte-serial RAM/IO bus.
- Arbitrates among three requesters:
  - committed stores from the reorder buffer (rob_mem_*);
  - loads from the load/store buffer;
  - 32-bit instruction fetches from the fetch unit.
- Serialises each access into byte transfers and reassembles load/fetch results.
- Returns results: mem_data_ready/mem_id to the ROB, if_ready/if_data to fetch.
- Drives mem_busy, which gates store commit in the ROB.

Parameters:
XLEN, 32, data/address width
ROB_SIZE_WIDTH, 3, width of ROB id tag
INST_OP_WIDTH, 6, width of op code; LB/LH/LW/LBU/LHU/SB/SH/SW values per global op encoding

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; when low all state frozen
flush  in  1  misprediction flush from ROB
io_buffer_full  in  1  UART output buffer full
rob_mem_enable  in  1  one-cycle store commit pulse
rob_mem_op  in  INST_OP_WIDTH  SB/SH/SW
rob_mem_addr  in  XLEN  store address
rob_mem_val  in  XLEN  store data
lsb_load_enable  in  1  load request, level-held
lsb_load_op  in  INST_OP_WIDTH  LB/LH/LW/LBU/LHU
lsb_load_addr  in  XLEN  load address
lsb_load_id  in  ROB_SIZE_WIDTH  ROB tag of load
if_enable  in  1  fetch request, level-held
if_addr  in  XLEN  fetch address (halfword aligned)
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte (registered)
mem_a  out  XLEN  RAM byte address (registered)
mem_wr  out  1  1=write, 0=read (registered)
mem_busy  out  1  state != IDLE (combinational)
mem_data_ready  out  1  load result valid, one-cycle pulse
mem_data  out  XLEN  extended load result
mem_id  out  ROB_SIZE_WIDTH  ROB tag of returned load
if_ready  out  1  fetch result valid, one-cycle pulse
if_data  out  XLEN  fetched word, little-endian

Behaviour:

Clock and reset
- Clock clk; reset rst, synchronous, active-high, effective only when rdy=1.
- Reset values: state=IDLE; mem_a=0, mem_dout=0, mem_wr=0; mem_data_ready=0, mem_data=0, mem_id=0; if_ready=0, if_data=0; byte counter=0.

States
- IDLE, READ, WRITE.
- Length n: 1 for B, 2 for H, 4 for W; fetch n=4.

Acceptance (IDLE only), priority store > load > fetch
- On accept edge E0, latch base addr, op, n, id, kind.
- E0 also registers mem_a=addr, mem_wr=is_store, and mem_dout=val[7:0] for stores.
- State moves to READ or WRITE.
- Loads and fetches are not accepted in a cycle where mem_data_ready or if_ready is high; the requester drops its enable in that cycle. Stores are still accepted in that cycle.

RAM timing
- mem_din in cycle t+1 holds the byte at mem_a of cycle t.

READ
- Byte k address is presented in cycle k+1 and captured at edge E(k+2).
- After the last address is issued, mem_a is driven to 0 with mem_wr=0.
- At E(n+1): assert the matching ready signal for one cycle and return to IDLE.
- Load result latency: LB 2 cycles, LH 3, LW 5 (edge count from E0).
- Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- mem_id = latched id.

WRITE
- Byte k (val[8k+7:8k]) is driven at addr+k in cycle k+1.
- Edge En sets mem_wr=0 and returns to IDLE, so mem_busy drops in cycle n+1.
- IO stall: if the next byte's address is in 0x30000..0x30007 and io_buffer_full=1, drive mem_wr=0, hold the counter, and retry each cycle.

Flush
- During a READ of a load or fetch, flush forces IDLE at the next edge, mem_a=0, and no ready pulse.
- This holds even when that edge would have completed the read.
- An in-progress WRITE is unaffected by flush.
- A store pulse coinciding with flush is still accepted.
- In IDLE, flush blocks load and fetch acceptance for that cycle.

Protocol assumptions
- rob_mem_enable while mem_busy=1 is a protocol violation: the request is ignored and a simulation assertion fires.
- Requesters hold op/addr/id stable until their ready pulse or a flush.

Address arithmetic
- Addresses are modulo 2^XLEN: addr+k wraps from 0xFFFFFFFF to 0.

Test Plan:
- Reset, then idle: all outputs 0, mem_busy=0.
- LW at 0x100, RAM bytes 0x11,0x22,0x33,0x84: mem_a sequence 0x100..0x103. At E5: mem_data_ready=1, mem_data=0x84332211, mem_id=tag. mem_busy=0 in the cycle after E5.
- LB at 0x103 (byte 0x84): mem_data=0xFFFFFF84. LBU at the same address: mem_data=0x00000084.
- SH val=0xABCD at 0x200: bus carries wr=1 a=0x200 d=0xCD, then wr=1 a=0x201 d=0xAB. mem_busy drops 2 cycles after accept.
- Store, load and fetch all requested in the same IDLE cycle: the store is accepted first, then the load, then the fetch.
- Load LW in flight, flush at cycle 2: no mem_data_ready; IDLE next cycle.
- SB to 0x30000 with io_buffer_full=1 for 3 cycles: mem_wr stays 0 for 3 cycles, then a single write occurs.
